// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // A 1-clock bit period still needs a 1-bit counter so the compare is well formed.
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter; tick marks the last clock of each bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Drains a FWFT byte FIFO onto an 8N1 UART line, reloading in the last
// stop-bit cycle so consecutive frames abut with no idle gap.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_en,
  input  logic                      fifo_empty,
  input  logic [UART_DATA_BITS-1:0] fifo_data,
  output logic                      fifo_rd,
  output logic                      tx,
  output logic                      busy,
  output logic                      frame_done
);

  tx_state_t                 state_reg, state_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [UART_IDX_W-1:0]     idx_reg, idx_next;
  logic                      tx_reg, tx_next;
  logic                      busy_reg, busy_next;
  logic                      done_reg, done_next;
  logic                      bit_tick;
  logic                      load;
  logic                      baud_clr;

  assign load = tx_en && !fifo_empty &&
                ((state_reg == IDLE) || ((state_reg == STOP) && bit_tick));

  // Holding the counter at zero while idle makes every START bit full length.
  assign baud_clr = load || (state_reg == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (bit_tick)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = START;
          shift_next = fifo_data;
        end
      end
      START: begin
        if (bit_tick) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == UART_IDX_W'(UART_DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + UART_IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (load) begin
            state_next = START;
            shift_next = fifo_data;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is registered from the upcoming state so tx changes on the same edge as the FSM.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_reg == STOP) && bit_tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign fifo_rd    = load;
  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

endmodule
